// File: rtl/tx_sig_conv_intlv_if.sv
// Serial SIGNAL-field bits in, interleaved coded bits out.
// Valid-only handshake: a bit moves on every rising edge where its valid is 1; there is no ready,
// and a source cannot be stalled (bits arriving while the block is busy are dropped and flagged).
interface tx_sig_conv_intlv_if;
    logic sig_bit_valid;
    logic sig_bit_in;
    logic intlv_out_valid;
    logic intlv_out_bit;
    logic intlv_done;
    logic sig_drop;

    modport master (
        output sig_bit_valid,
        output sig_bit_in,
        input  intlv_out_valid,
        input  intlv_out_bit,
        input  intlv_done,
        input  sig_drop
    );

    modport slave (
        input  sig_bit_valid,
        input  sig_bit_in,
        output intlv_out_valid,
        output intlv_out_bit,
        output intlv_done,
        output sig_drop
    );
endinterface

// File: rtl/tx_sig_conv_intlv.sv
// SIGNAL field path: K=7 rate-1/2 convolutional encoder (g0=133, g1=171) feeding a
// 48-bit BPSK block interleaver, then a 48-cycle serial readout.
module tx_sig_conv_intlv (
    input  logic                      clk_Modulation,
    input  logic                      reset_n,
    tx_sig_conv_intlv_if.slave        sig_if,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  n_cnt, n_nxt;
    logic [5:0]  i_cnt, i_nxt;
    logic [5:0]  sr, sr_nxt;
    logic        out_valid, out_valid_nxt;
    logic        out_bit, out_bit_nxt;
    logic        done, done_nxt;
    logic        drop, drop_nxt;
    logic        we;
    logic [47:0] intlv_buf;
    logic [5:0]  d_eff;
    logic        bit_a, bit_b;
    logic [5:0]  pos_a, pos_b;
    logic [5:0]  i_inc;

    // Interleaved position of coded bit k: 3*(k mod 16) + floor(k/16).
    function automatic logic [5:0] intlv_pos(input logic [5:0] k);
        return ({2'b00, k[3:0]} * 6'd3) + {4'b0000, k[5:4]};
    endfunction

    // sr[0] is d1 (previous bit) ... sr[5] is d6. IDLE presents a cleared register so the
    // first bit of a frame encodes from zero state without an extra clear cycle.
    assign d_eff = (state == IDLE) ? 6'b0 : sr;
    assign bit_a = sig_if.sig_bit_in ^ d_eff[1] ^ d_eff[2] ^ d_eff[4] ^ d_eff[5];
    assign bit_b = sig_if.sig_bit_in ^ d_eff[0] ^ d_eff[1] ^ d_eff[2] ^ d_eff[5];
    assign pos_a = intlv_pos({n_cnt, 1'b0});
    assign pos_b = intlv_pos({n_cnt, 1'b1});
    assign i_inc = i_cnt + 6'd1;

    always_comb begin
        state_nxt     = state;
        n_nxt         = n_cnt;
        i_nxt         = i_cnt;
        sr_nxt        = sr;
        out_valid_nxt = 1'b0;
        out_bit_nxt   = 1'b0;
        done_nxt      = 1'b0;
        drop_nxt      = 1'b0;
        we            = 1'b0;
        case (state)
            IDLE: begin
                if (sig_if.sig_bit_valid) begin
                    we        = 1'b1;
                    sr_nxt    = {d_eff[4:0], sig_if.sig_bit_in};
                    n_nxt     = 5'd1;
                    state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                if (sig_if.sig_bit_valid) begin
                    we     = 1'b1;
                    sr_nxt = {d_eff[4:0], sig_if.sig_bit_in};
                    if (n_cnt == 5'd23) begin
                        // Position 0 is never among the last two writes, so it is safe to read now.
                        n_nxt         = 5'd0;
                        i_nxt         = 6'd0;
                        state_nxt     = OUTPUT;
                        out_valid_nxt = 1'b1;
                        out_bit_nxt   = intlv_buf[0];
                    end else begin
                        n_nxt = n_cnt + 5'd1;
                    end
                end
            end
            OUTPUT: begin
                drop_nxt = sig_if.sig_bit_valid;
                if (i_cnt == 6'd47) begin
                    i_nxt     = 6'd0;
                    state_nxt = IDLE;
                end else begin
                    i_nxt         = i_inc;
                    out_valid_nxt = 1'b1;
                    out_bit_nxt   = intlv_buf[i_inc];
                    done_nxt      = (i_inc == 6'd47);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_Modulation or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            n_cnt     <= 5'd0;
            i_cnt     <= 6'd0;
            sr        <= 6'd0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            done      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            n_cnt     <= n_nxt;
            i_cnt     <= i_nxt;
            sr        <= sr_nxt;
            out_valid <= out_valid_nxt;
            out_bit   <= out_bit_nxt;
            done      <= done_nxt;
            drop      <= drop_nxt;
        end
    end

    // Coded-bit store; contents survive reset because every frame rewrites all 48 entries.
    always_ff @(posedge clk_Modulation) begin
        if (we) begin
            intlv_buf[pos_a] <= bit_a;
            intlv_buf[pos_b] <= bit_b;
        end
    end

    assign sig_if.intlv_out_valid = out_valid;
    assign sig_if.intlv_out_bit   = out_bit;
    assign sig_if.intlv_done      = done;
    assign sig_if.sig_drop        = drop;
    assign dbg_state              = state;

endmodule

// File: tb/tb_tx_sig_conv_intlv.sv
// Bench for tx_sig_conv_intlv: random and directed SIGNAL frames checked every cycle
// against a convolution/interleave reference computed from the frame bits.
module tb_tx_sig_conv_intlv;

  // ---------------- clock / reset ----------------
  logic       clk_Modulation = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  tx_sig_conv_intlv_if sig_if ();

  tx_sig_conv_intlv dut (
    .clk_Modulation (clk_Modulation),
    .reset_n        (reset_n),
    .sig_if         (sig_if),
    .dbg_state      (dbg_state)
  );

  always #5 clk_Modulation = ~clk_Modulation;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // f[n] is the n-th transmitted bit; returns bit i = interleaved output position i.
  function automatic logic [47:0] golden(input logic [23:0] f);
    logic [6:0]  g0;
    logic [6:0]  g1;
    logic [47:0] coded;
    logic [47:0] r;
    logic        a;
    logic        b;
    g0 = 7'o133;
    g1 = 7'o171;
    coded = '0;
    r = '0;
    for (int n = 0; n < 24; n++) begin
      a = 1'b0;
      b = 1'b0;
      for (int j = 0; j < 7; j++) begin
        if (n - j >= 0) begin
          if (g0[6-j]) a = a ^ f[n-j];
          if (g1[6-j]) b = b ^ f[n-j];
        end
      end
      coded[2*n]   = a;
      coded[2*n+1] = b;
    end
    for (int k = 0; k < 48; k++) r[3*(k%16) + k/16] = coded[k];
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [0:0]  exp_q[$];
  int          acc_cnt = 0;
  logic [23:0] acc_bits = '0;
  int          out_rem = 0;
  int          out_idx = 0;
  logic        drop_pend = 1'b0;
  logic [47:0] cap = '0;
  int          frames_out = 0;
  int          drops_seen = 0;

  always @(negedge clk_Modulation) begin
    logic [47:0] g;
    logic [1:0]  exp_state;
    logic [0:0]  e;
    if (!reset_n) begin
      check("rst_out_valid", 48'(sig_if.intlv_out_valid), 48'd0);
      check("rst_out_bit", 48'(sig_if.intlv_out_bit), 48'd0);
      check("rst_done", 48'(sig_if.intlv_done), 48'd0);
      check("rst_drop", 48'(sig_if.sig_drop), 48'd0);
      check("rst_state", 48'(dbg_state), 48'd0);
      acc_cnt   = 0;
      out_rem   = 0;
      drop_pend = 1'b0;
      exp_q.delete();
    end else begin
      exp_state = (out_rem > 0) ? 2'd2 : ((acc_cnt > 0) ? 2'd1 : 2'd0);
      check("state", 48'(dbg_state), 48'(exp_state));
      check("sig_drop", 48'(sig_if.sig_drop), 48'(drop_pend));
      if (sig_if.sig_drop) drops_seen++;
      drop_pend = 1'b0;
      if (out_rem > 0) begin
        e = exp_q.pop_front();
        check("out_valid", 48'(sig_if.intlv_out_valid), 48'd1);
        check("out_bit", 48'(sig_if.intlv_out_bit), 48'(e));
        check("done", 48'(sig_if.intlv_done), 48'(out_rem == 1));
        cap[out_idx] = sig_if.intlv_out_bit;
        out_idx++;
        if (sig_if.sig_bit_valid) drop_pend = 1'b1;
        out_rem--;
        if (out_rem == 0) frames_out++;
      end else begin
        check("idle_valid", 48'(sig_if.intlv_out_valid), 48'd0);
        check("idle_bit", 48'(sig_if.intlv_out_bit), 48'd0);
        check("idle_done", 48'(sig_if.intlv_done), 48'd0);
        if (sig_if.sig_bit_valid) begin
          acc_bits[acc_cnt] = sig_if.sig_bit_in;
          acc_cnt++;
          if (acc_cnt == 24) begin
            g = golden(acc_bits);
            for (int i = 0; i < 48; i++) exp_q.push_back(g[i]);
            out_rem = 48;
            out_idx = 0;
            acc_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [23:0] f, input int nbits, input int max_gap, input int hold);
    int gap;
    for (int n = 0; n < nbits; n++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(posedge clk_Modulation); #1;
        sig_if.sig_bit_valid = 1'b0;
        sig_if.sig_bit_in    = 1'($urandom);
      end
      @(posedge clk_Modulation); #1;
      sig_if.sig_bit_valid = 1'b1;
      sig_if.sig_bit_in    = f[n];
    end
    repeat (hold) begin
      @(posedge clk_Modulation); #1;
      sig_if.sig_bit_in = 1'($urandom);
    end
    @(posedge clk_Modulation); #1;
    sig_if.sig_bit_valid = 1'b0;
    sig_if.sig_bit_in    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk_Modulation); #1;
      if (sig_if.intlv_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 48'(seen), 48'd1);
  endtask

  // Caller is positioned just after a rising edge; reset lands mid-cycle.
  task automatic do_reset(input string name);
    #1;
    reset_n = 1'b0;
    sig_if.sig_bit_valid = 1'b0;
    sig_if.sig_bit_in    = 1'b0;
    #1;
    check({name, "_valid"}, 48'(sig_if.intlv_out_valid), 48'd0);
    check({name, "_bit"}, 48'(sig_if.intlv_out_bit), 48'd0);
    check({name, "_done"}, 48'(sig_if.intlv_done), 48'd0);
    check({name, "_state"}, 48'(dbg_state), 48'd0);
    repeat (2) @(posedge clk_Modulation);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  int frames_exp = 0;
  int d0;
  int f0;
  int seen_i;
  bit hit;

  initial begin
    sig_if.sig_bit_valid = 1'b0;
    sig_if.sig_bit_in    = 1'b0;
    repeat (3) @(posedge clk_Modulation);
    #1;
    reset_n = 1'b1;

    // Model pins: impulse response lands on positions 0,3,9,12,15,18,21,30,36,39.
    check("golden_impulse", golden(24'h000001), 48'h009040249209);
    check("golden_zero", golden(24'h000000), 48'h0);

    // All-zero frame, contiguous valid.
    send_bits(24'h000000, 24, 0, 0);
    wait_done("done_zero");
    frames_exp++;
    repeat (2) @(posedge clk_Modulation);
    check("cap_zero", cap, 48'h0);

    // Impulse, contiguous then with random gaps.
    cap = '1;
    send_bits(24'h000001, 24, 0, 0);
    wait_done("done_imp");
    frames_exp++;
    repeat (2) @(posedge clk_Modulation);
    check("cap_impulse", cap, 48'h009040249209);

    cap = '0;
    send_bits(24'h000001, 24, 3, 0);
    wait_done("done_imp_gap");
    frames_exp++;
    repeat (2) @(posedge clk_Modulation);
    check("cap_impulse_gap", cap, 48'h009040249209);

    // Valid held high through the whole readout.
    d0 = drops_seen;
    f0 = frames_out;
    send_bits(24'($urandom), 24, 0, 48);
    frames_exp++;
    repeat (3) @(posedge clk_Modulation);
    #1;
    check("hold_drops", 48'(drops_seen - d0), 48'd48);
    check("hold_frames", 48'(frames_out - f0), 48'd1);
    check("hold_idle", 48'(dbg_state), 48'd0);

    // Reset while encoding (n=10), then a clean frame.
    send_bits(24'($urandom), 10, 0, 0);
    do_reset("rst_enc");
    send_bits(24'($urandom), 24, 1, 0);
    wait_done("done_after_rst_enc");
    frames_exp++;

    // Reset mid-readout at i=20, then a clean frame.
    send_bits(24'($urandom), 24, 0, 0);
    seen_i = 0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_Modulation); #1;
      if (sig_if.intlv_out_valid) begin
        if (seen_i == 20) begin
          hit = 1'b1;
          break;
        end
        seen_i++;
      end
    end
    check("reach_i20", 48'(hit), 48'd1);
    do_reset("rst_out");
    send_bits(24'($urandom), 24, 0, 0);
    wait_done("done_after_rst_out");
    frames_exp++;

    // Back-to-back: second frame starts the cycle after intlv_done.
    send_bits(24'($urandom), 24, 0, 0);
    wait_done("done_b2b_a");
    frames_exp++;
    send_bits(24'($urandom), 24, 0, 0);
    wait_done("done_b2b_b");
    frames_exp++;

    // Random frames with varying gap widths.
    for (int r = 0; r < 6; r++) begin
      send_bits(24'($urandom), 24, r % 4, 0);
      wait_done("done_rand");
      frames_exp++;
    end

    repeat (5) @(posedge clk_Modulation);
    #1;
    check("exp_q_empty", 48'(exp_q.size()), 48'd0);
    check("frames_out", 48'(frames_out), 48'(frames_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
